itrx_amba4_axi_burst_addr_gen: RTL

AXI4 burst address generator: accepts one AR- or AW-channel command (address, ID, length, size, burst type) over a valid/ready handshake and expands it into a stream of per-beat addresses with a last flag and a protocol-error flag. It sits directly downstream of an AXI4 slave's AR/AW channel register and feeds the slave's memory/register access datapath. It uses the shared AMBA4 AXI package types (t_xaddr, t_xid, te_xlen, te_xsize, te_xburst).

---
 rtl/itrx_amba4_axi_burst_addr_gen.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/itrx_amba4_axi_burst_addr_gen.sv
// AXI4 burst address generator.
// Takes one AR/AW command over a valid/ready handshake and expands it into
// one address per beat, with beat index, last flag and a burst-wide error flag.
// The shared AMBA4 AXI types live in the package at the top of this file.

package itrx_amba4_axi_pkg;

   typedef logic [31:0] t_xaddr;
   typedef logic [3:0]  t_xid;
   typedef logic [7:0]  te_xlen;
   typedef logic [2:0]  te_xsize;
   typedef logic [1:0]  te_xburst;

   // AxBURST encodings
   localparam te_xburst XBURST_FIXED = 2'b00;
   localparam te_xburst XBURST_INCR  = 2'b01;
   localparam te_xburst XBURST_WRAP  = 2'b10;
   localparam te_xburst XBURST_RSVD  = 2'b11;

   // AxSIZE encodings (bytes per beat = 2^size)
   localparam te_xsize XSIZE_BYTE     = 3'd0;
   localparam te_xsize XSIZE_HALFWORD = 3'd1;
   localparam te_xsize XSIZE_WORD     = 3'd2;
   localparam te_xsize XSIZE_DBLWORD  = 3'd3;

endpackage

module itrx_amba4_axi_burst_addr_gen
   import itrx_amba4_axi_pkg::*;
#(
   parameter int unsigned MAX_SIZE = 2
) (
   input  logic           clk,
   input  logic           rst,

   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  t_xaddr         cmd_addr,
   input  t_xid           cmd_id,
   input  te_xlen         cmd_len,
   input  te_xsize        cmd_size,
   input  te_xburst       cmd_burst,

   output logic           beat_valid,
   input  logic           beat_ready,
   output t_xaddr         beat_addr,
   output t_xid           beat_id,
   output te_xsize        beat_size,
   output te_xlen         beat_idx,
   output logic           beat_last,
   output logic           beat_err
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } t_state;

   // ------------------------------------------------------------------
   // State and beat registers
   // ------------------------------------------------------------------
   t_state     state_reg;
   logic       beat_valid_reg;
   t_xaddr     beat_addr_reg;
   t_xid       beat_id_reg;
   te_xsize    beat_size_reg;
   te_xlen     beat_idx_reg;
   logic       beat_last_reg;
   logic       beat_err_reg;

   // Per-burst context kept alongside the beat register
   te_xlen     len_reg;
   te_xburst   mode_reg;         // effective burst type used for addressing
   t_xaddr     wrap_lower_reg;   // lowest address of the wrap window
   t_xaddr     wrap_upper_reg;   // one past the highest address of the window

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   logic beat_fire;
   logic cmd_accept;

   assign beat_fire  = beat_valid_reg & beat_ready;
   // A new command can be taken when idle, or in the same cycle the final
   // beat of the current burst is consumed, which gives zero-bubble
   // back-to-back bursts. Held low while reset is asserted.
   assign cmd_ready  = ~rst & ((state_reg == ST_IDLE) | (beat_fire & beat_last_reg));
   assign cmd_accept = cmd_valid & cmd_ready;

   // ------------------------------------------------------------------
   // Command decode: error checks and wrap window, evaluated at accept
   // ------------------------------------------------------------------
   t_xaddr    cmd_size_mask;
   t_xaddr    cmd_aligned;
   t_xaddr    cmd_total_bytes;
   t_xaddr    cmd_wrap_lower;
   t_xaddr    cmd_wrap_upper;
   logic [32:0] cmd_end_addr;
   logic      cmd_wrap_len_ok;
   logic      cmd_err_size;
   logic      cmd_err_rsvd;
   logic      cmd_err_wrap_len;
   logic      cmd_err_wrap_align;
   logic      cmd_err_4k;
   logic      cmd_err;
   te_xburst  cmd_mode;

   // Decode the incoming command into its address context and error flag
   always_comb begin
      cmd_size_mask   = (32'd1 << cmd_size) - 32'd1;
      cmd_aligned     = cmd_addr & ~cmd_size_mask;
      // Total burst size in bytes; (len+1) << size never exceeds 32 KB
      cmd_total_bytes = (32'(cmd_len) + 32'd1) << cmd_size;

      cmd_wrap_lower  = cmd_addr & ~(cmd_total_bytes - 32'd1);
      cmd_wrap_upper  = cmd_wrap_lower + cmd_total_bytes;

      // Last byte of an INCR burst, kept in 33 bits so that running off the
      // top of the 32-bit address space also shows up as a page change
      cmd_end_addr    = {1'b0, cmd_aligned} + {1'b0, cmd_total_bytes} - 33'd1;

      cmd_wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                        (cmd_len == 8'd7) || (cmd_len == 8'd15);

      cmd_err_size       = (cmd_size > 3'(MAX_SIZE));
      cmd_err_rsvd       = (cmd_burst == XBURST_RSVD);
      cmd_err_wrap_len   = (cmd_burst == XBURST_WRAP) && !cmd_wrap_len_ok;
      cmd_err_wrap_align = (cmd_burst == XBURST_WRAP) && ((cmd_addr & cmd_size_mask) != 32'd0);
      // Start and end lie in different 4 KB pages when any bit at or above
      // bit 12 differs, i.e. when their XOR reaches 0x1000
      cmd_err_4k         = (cmd_burst == XBURST_INCR) &&
                           ((cmd_end_addr ^ {1'b0, cmd_aligned}) > 33'h0_0000_0FFF);

      cmd_err = cmd_err_size | cmd_err_rsvd | cmd_err_wrap_len |
                cmd_err_wrap_align | cmd_err_4k;

      // Reserved bursts and malformed wraps are walked as INCR
      if (cmd_err_rsvd || cmd_err_wrap_len) begin
         cmd_mode = XBURST_INCR;
      end else begin
         cmd_mode = cmd_burst;
      end
   end

   // ------------------------------------------------------------------
   // Next-beat address from the current beat register
   // ------------------------------------------------------------------
   t_xaddr  cur_size_mask;
   t_xaddr  cur_aligned;
   t_xaddr  cur_sum;
   t_xaddr  addr_next;
   te_xlen  idx_next;

   // Step the address: aligned current address plus one beat, wrapping at the window top
   always_comb begin
      cur_size_mask = (32'd1 << beat_size_reg) - 32'd1;
      cur_aligned   = beat_addr_reg & ~cur_size_mask;
      cur_sum       = cur_aligned + (32'd1 << beat_size_reg);
      idx_next      = beat_idx_reg + 8'd1;

      case (mode_reg)
         XBURST_FIXED: addr_next = beat_addr_reg;
         XBURST_WRAP:  addr_next = (cur_sum == wrap_upper_reg) ? wrap_lower_reg : cur_sum;
         default:      addr_next = cur_sum;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM with registered beat outputs
   // ------------------------------------------------------------------
   // Load beat 0 on accept, step on each consumed non-final beat, go idle when drained
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         beat_valid_reg <= 1'b0;
         beat_addr_reg  <= '0;
         beat_id_reg    <= '0;
         beat_size_reg  <= '0;
         beat_idx_reg   <= '0;
         beat_last_reg  <= 1'b0;
         beat_err_reg   <= 1'b0;
         len_reg        <= '0;
         mode_reg       <= XBURST_FIXED;
         wrap_lower_reg <= '0;
         wrap_upper_reg <= '0;
      end else begin
         if (cmd_accept) begin
            // Covers both the idle accept and the back-to-back accept on
            // the final beat of the previous burst
            state_reg      <= ST_BURST;
            beat_valid_reg <= 1'b1;
            beat_addr_reg  <= cmd_addr;
            beat_id_reg    <= cmd_id;
            beat_size_reg  <= cmd_size;
            beat_idx_reg   <= 8'd0;
            beat_last_reg  <= (cmd_len == 8'd0);
            beat_err_reg   <= cmd_err;
            len_reg        <= cmd_len;
            mode_reg       <= cmd_mode;
            wrap_lower_reg <= cmd_wrap_lower;
            wrap_upper_reg <= cmd_wrap_upper;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  beat_valid_reg <= 1'b0;
               end
               ST_BURST: begin
                  if (beat_fire) begin
                     if (beat_last_reg) begin
                        // Burst drained and no follow-on command
                        state_reg      <= ST_IDLE;
                        beat_valid_reg <= 1'b0;
                        beat_last_reg  <= 1'b0;
                     end else begin
                        beat_addr_reg  <= addr_next;
                        beat_idx_reg   <= idx_next;
                        beat_last_reg  <= (idx_next == len_reg);
                     end
                  end
               end
               default: begin
                  state_reg      <= ST_IDLE;
                  beat_valid_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign beat_valid = beat_valid_reg;
   assign beat_addr  = beat_addr_reg;
   assign beat_id    = beat_id_reg;
   assign beat_size  = beat_size_reg;
   assign beat_idx   = beat_idx_reg;
   assign beat_last  = beat_last_reg;
   assign beat_err   = beat_err_reg;

endmodule
